// File: rtl/adder17.sv
// Registered 3-bit ripple-carry adder slice: {po3..po0} = A + B + cin, one cycle after capture.
// Operands A = {pi6,pi5,pi4}, B = {pi3,pi2,pi1}, carry-in pi0; the result is exact.
module adder17 (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic pi6,
    input  logic pi5,
    input  logic pi4,
    input  logic pi3,
    input  logic pi2,
    input  logic pi1,
    input  logic pi0,
    output logic po3,
    output logic po2,
    output logic po1,
    output logic po0,
    output logic out_valid
);

    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [2:0] sum;
    logic [3:0] carry;
    logic [3:0] result_q;
    logic       valid_q;

    assign op_a     = {pi6, pi5, pi4};
    assign op_b     = {pi3, pi2, pi1};
    assign carry[0] = pi0;

    // Three chained full adders; carry[3] is the carry-out and result bit 3.
    for (genvar i = 0; i < 3; i++) begin : gen_fa
        assign sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
        assign carry[i+1] = (op_a[i] & op_b[i]) | (op_a[i] & carry[i]) | (op_b[i] & carry[i]);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= {carry[3], sum};
            end
        end
    end

    assign {po3, po2, po1, po0} = result_q;
    assign out_valid            = valid_q;

endmodule

// File: tb/tb_adder17.sv
// Self-checking bench for adder17: corner-value table, hold, reset sequences and an
// exhaustive back-to-back sweep, with expected results queued at drive time.
module tb_adder17;

    typedef struct {
        string      name;
        logic [6:0] pi;
        logic [3:0] po;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] pi = 7'd0;
    logic       po3, po2, po1, po0, out_valid;
    logic [3:0] po;
    logic [3:0] held;
    logic [3:0] exp_q[$];
    vec_t       vecs[6];
    int         n_cmp = 0;
    int         n_fail = 0;

    adder17 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pi6       (pi[6]),
        .pi5       (pi[5]),
        .pi4       (pi[4]),
        .pi3       (pi[3]),
        .pi2       (pi[2]),
        .pi1       (pi[1]),
        .pi0       (pi[0]),
        .po3       (po3),
        .po2       (po2),
        .po1       (po1),
        .po0       (po0),
        .out_valid (out_valid)
    );

    assign po = {po3, po2, po1, po0};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [3:0] model(input logic [6:0] v);
        return 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
    endfunction

    // Drive one cycle; a valid capture queues its expectation, an idle one expects the held value.
    task automatic step(input string name, input logic [6:0] v, input logic valid, input logic [3:0] exp_v);
        pi       = v;
        in_valid = valid;
        if (valid) exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check({name, "/queue_empty"}, 8'd0, 8'd1);
            end else begin
                held = exp_q.pop_front();
                check({name, "/po"}, {4'd0, po}, {4'd0, held});
            end
            check({name, "/out_valid"}, {7'd0, out_valid}, 8'd1);
        end else begin
            check({name, "/po_hold"}, {4'd0, po}, {4'd0, held});
            check({name, "/out_valid_low"}, {7'd0, out_valid}, 8'd0);
        end
    endtask

    initial begin
        vecs[0] = '{"zero",     7'b0000000, 4'b0000};
        vecs[1] = '{"cin_only", 7'b0000001, 4'b0001};
        vecs[2] = '{"all_ones", 7'b1111111, 4'b1111};
        vecs[3] = '{"a7_b0",    7'b1110000, 4'b0111};
        vecs[4] = '{"a4_b4_c1", 7'b1001001, 4'b1001};
        vecs[5] = '{"ripple",   7'b1000111, 4'b1000};
        held = 4'd0;

        // Reset state at power-up
        #12;
        check("por/po", {4'd0, po}, 8'd0);
        check("por/out_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset from po = 1111, no clock edge involved
        step("pre_reset", 7'b1111111, 1'b1, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst/po", {4'd0, po}, 8'd0);
        check("async_rst/out_valid", {7'd0, out_valid}, 8'd0);
        held = 4'd0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle_after_rst", 7'($urandom_range(0, 127)), 1'b0, 4'd0);

        // Corner values, back-to-back
        for (int i = 0; i < 6; i++) step(vecs[i].name, vecs[i].pi, 1'b1, vecs[i].po);

        // Hold: drop in_valid and change operands
        step("hold_load", 7'b0110101, 1'b1, 4'b0110);
        step("hold_1", 7'b1010101, 1'b0, 4'd0);
        step("hold_2", 7'b1111111, 1'b0, 4'd0);

        // Exhaustive sweep with an asynchronous reset landing mid-stream
        for (int i = 0; i < 128; i++) begin
            step("sweep", 7'(i), 1'b1, model(7'(i)));
            if (i == 64) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("sweep_rst/po", {4'd0, po}, 8'd0);
                check("sweep_rst/out_valid", {7'd0, out_valid}, 8'd0);
                held = 4'd0;
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        step("sweep_end_idle", 7'd0, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
